// File: rtl/bram_dp_be.sv
// Dual-port byte-enable block RAM, shared clock, write-first/read-first same-port mode,
// optional output register and post-reset zero sweep. Macro BRAM_COLLISION_CHECK_EN enables the collision flag.
module bram_dp_be #(
    parameter int WIDTH    = 32,
    parameter int SCALE    = 10,
    parameter int RDW_MODE = 0,
    parameter int OUTREG   = 0,
    parameter int CLEAR    = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               oe0,
    input  logic [SCALE-1:0]   addr0,
    input  logic [WIDTH-1:0]   wdata0,
    input  logic [WIDTH/8-1:0] be0,
    output logic [WIDTH-1:0]   rdata0,
    output logic               rvalid0,
    input  logic               oe1,
    input  logic [SCALE-1:0]   addr1,
    input  logic [WIDTH-1:0]   wdata1,
    input  logic [WIDTH/8-1:0] be1,
    output logic [WIDTH-1:0]   rdata1,
    output logic               rvalid1,
    output logic               collision
);

    localparam int LANES = WIDTH / 8;
    localparam int DEPTH = 1 << SCALE;

    generate
        if (((WIDTH % 8) != 0) || (SCALE < 1)) begin : g_cfg_err
            $error("bram_dp_be: WIDTH must be a multiple of 8 and SCALE must be >= 1");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [SCALE-1:0]             cnt_q, cnt_d;
    logic                         ready_q, ready_d;
    logic                         clr_we_s;

    logic [WIDTH-1:0]             mem_q [DEPTH];

    logic [1:0]                   oe_s;
    logic [1:0][SCALE-1:0]        addr_s;
    logic [1:0][WIDTH-1:0]        wdata_s;
    logic [1:0][LANES-1:0]        be_s;
    logic [1:0]                   acc_s;
    logic [1:0]                   we_s;
    logic [1:0][WIDTH-1:0]        old_s;
    logic [1:0][WIDTH-1:0]        merged_s;
    logic [1:0][WIDTH-1:0]        res_s;

    logic [1:0][WIDTH-1:0]        s1_data_q, s1_data_d;
    logic [1:0]                   s1_valid_q, s1_valid_d;
    logic [1:0][WIDTH-1:0]        out_data_s;
    logic [1:0]                   out_valid_s;

    assign oe_s    = {oe1, oe0};
    assign addr_s  = {addr1, addr0};
    assign wdata_s = {wdata1, wdata0};
    assign be_s    = {be1, be0};

    // Sequencer: zero sweep (when enabled) then normal operation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        clr_we_s = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we_s = 1'b1;
                cnt_d    = cnt_q + SCALE'(1);
                if (cnt_q == {SCALE{1'b1}}) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = S_CLEAR;
                    ready_d = 1'b0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                ready_d = 1'b0;
            end
        endcase
    end

    // Request acceptance and the word each port returns (merged own lanes or pre-write word).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc_s[p]    = oe_s[p] & ready_q;
            we_s[p]     = acc_s[p] & (|be_s[p]);
            old_s[p]    = mem_q[addr_s[p]];
            merged_s[p] = old_s[p];
            for (int l = 0; l < LANES; l++) begin
                if (be_s[p][l]) begin
                    merged_s[p][8*l +: 8] = wdata_s[p][8*l +: 8];
                end else begin
                    merged_s[p][8*l +: 8] = old_s[p][8*l +: 8];
                end
            end
            if (RDW_MODE == 0) begin
                res_s[p] = merged_s[p];
            end else begin
                res_s[p] = old_s[p];
            end
        end
    end

    // Storage array; port 0 lanes are written last so they win a same-address, same-lane clash.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (we_s[1] && be_s[1][l]) begin
                    mem_q[addr_s[1]][8*l +: 8] <= wdata_s[1][8*l +: 8];
                end
                if (we_s[0] && be_s[0][l]) begin
                    mem_q[addr_s[0]][8*l +: 8] <= wdata_s[0][8*l +: 8];
                end
            end
        end
    end

    // First read stage: data holds between requests.
    always_comb begin
        s1_valid_d = acc_s;
        for (int p = 0; p < 2; p++) begin
            if (acc_s[p]) begin
                s1_data_d[p] = res_s[p];
            end else begin
                s1_data_d[p] = s1_data_q[p];
            end
        end
    end

    // Control and first-stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR != 0) ? S_CLEAR : S_RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            s1_data_q  <= '0;
            s1_valid_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [1:0][WIDTH-1:0] s2_data_q, s2_data_d;
            logic [1:0]            s2_valid_q, s2_valid_d;

            // Second read stage captures only valid first-stage results.
            always_comb begin
                s2_valid_d = s1_valid_q;
                for (int p = 0; p < 2; p++) begin
                    if (s1_valid_q[p]) begin
                        s2_data_d[p] = s1_data_q[p];
                    end else begin
                        s2_data_d[p] = s2_data_q[p];
                    end
                end
            end

            // Output register stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 2'b00;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s2_valid_d;
                end
            end

            assign out_data_s  = s2_data_q;
            assign out_valid_s = s2_valid_q;
        end else begin : g_direct
            assign out_data_s  = s1_data_q;
            assign out_valid_s = s1_valid_q;
        end
    endgenerate

    assign ready   = ready_q;
    assign rdata0  = out_data_s[0];
    assign rdata1  = out_data_s[1];
    assign rvalid0 = out_valid_s[0];
    assign rvalid1 = out_valid_s[1];

`ifdef BRAM_COLLISION_CHECK_EN
    logic collision_q, collision_d;

    // Flag a same-address write from both ports in the previous cycle.
    always_comb begin
        collision_d = we_s[0] & we_s[1] & (addr_s[0] == addr_s[1]);
    end

    // Collision flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_bram_dp_be.sv
// Bench for bram_dp_be: instance A (write-first, latency 1, zero sweep) and
// instance B (read-first, latency 2, no sweep) share stimulus and are checked against a word-level model.
module tb_bram_dp_be;

    localparam int W = 32;
    localparam int S = 4;
    localparam int D = 16;
`ifdef BRAM_COLLISION_CHECK_EN
    localparam bit COL_EN = 1'b1;
`else
    localparam bit COL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         oe0, oe1;
    logic [S-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic [3:0]   be0, be1;

    logic [W-1:0] dut_rd    [2][2];
    logic         dut_rv    [2][2];
    logic         dut_ready [2];
    logic         dut_col   [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bram_dp_be #(.WIDTH(W), .SCALE(S), .RDW_MODE(0), .OUTREG(0), .CLEAR(1)) dut_a (
        .clk(clk), .rst(rst), .ready(dut_ready[0]),
        .oe0(oe0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .rdata0(dut_rd[0][0]), .rvalid0(dut_rv[0][0]),
        .oe1(oe1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .rdata1(dut_rd[0][1]), .rvalid1(dut_rv[0][1]),
        .collision(dut_col[0])
    );

    bram_dp_be #(.WIDTH(W), .SCALE(S), .RDW_MODE(1), .OUTREG(1), .CLEAR(0)) dut_b (
        .clk(clk), .rst(rst), .ready(dut_ready[1]),
        .oe0(oe0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .rdata0(dut_rd[1][0]), .rvalid0(dut_rv[1][0]),
        .oe1(oe1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .rdata1(dut_rd[1][1]), .rvalid1(dut_rv[1][1]),
        .collision(dut_col[1])
    );

    // Reference model state: k = 0 for instance A, 1 for instance B.
    logic [W-1:0] mm      [2][D];
    bit           m_ready [2];
    int           m_cnt   [2];
    logic [W-1:0] m_out_d [2][2];
    bit           m_out_v [2][2];
    logic [W-1:0] m_s1_d  [2][2];
    bit           m_s1_v  [2][2];
    bit           m_col   [2];

    typedef struct {
        bit          oe0;
        logic [3:0]  a0;
        logic [31:0] wd0;
        logic [3:0]  be0;
        bit          oe1;
        logic [3:0]  a1;
        logic [31:0] wd1;
        logic [3:0]  be1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
        bit          cb;
        bit          col;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [31:0] junk(input int k, input int i);
        return 32'hDEADBEEF ^ (i * 32'h01030507) ^ ((k == 1) ? 32'h5A5A0000 : 32'h0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 1'b0;
            m_cnt[k]   = 0;
            m_col[k]   = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_out_d[k][p] = '0;
                m_out_v[k][p] = 1'b0;
                m_s1_d[k][p]  = '0;
                m_s1_v[k][p]  = 1'b0;
            end
        end
    endtask

    // One clock edge worth of behaviour, from the current (stable) inputs.
    task automatic model_edge();
        bit           acc [2];
        logic [W-1:0] res [2];
        logic [S-1:0] ad  [2];
        logic [W-1:0] wd  [2];
        logic [3:0]   bb  [2];
        ad[0] = addr0; ad[1] = addr1;
        wd[0] = wdata0; wd[1] = wdata1;
        bb[0] = be0; bb[1] = be1;
        for (int k = 0; k < 2; k++) begin
            acc[0] = oe0 && m_ready[k];
            acc[1] = oe1 && m_ready[k];
            for (int p = 0; p < 2; p++) begin
                if (k == 0) res[p] = merge(mm[k][ad[p]], wd[p], bb[p]);
                else        res[p] = mm[k][ad[p]];
            end
            m_col[k] = COL_EN && acc[0] && acc[1] && (be0 != 4'h0) && (be1 != 4'h0) && (addr0 == addr1);
            for (int l = 0; l < 4; l++) begin
                if (acc[0] && bb[0][l])
                    mm[k][ad[0]][8*l +: 8] = wd[0][8*l +: 8];
                if (acc[1] && bb[1][l] && !(acc[0] && bb[0][l] && ad[0] == ad[1]))
                    mm[k][ad[1]][8*l +: 8] = wd[1][8*l +: 8];
            end
            if (!m_ready[k]) begin
                if (k == 0) begin
                    mm[k][m_cnt[k]] = '0;
                    m_cnt[k]++;
                    if (m_cnt[k] == D) m_ready[k] = 1'b1;
                end else begin
                    m_ready[k] = 1'b1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (k == 1) begin
                    if (m_s1_v[k][p]) m_out_d[k][p] = m_s1_d[k][p];
                    m_out_v[k][p] = m_s1_v[k][p];
                    m_s1_v[k][p]  = acc[p];
                    if (acc[p]) m_s1_d[k][p] = res[p];
                end else begin
                    m_out_v[k][p] = acc[p];
                    if (acc[p]) m_out_d[k][p] = res[p];
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s k%0d ready", tag, k), 32'(dut_ready[k]), 32'(m_ready[k]));
            chk($sformatf("%s k%0d collision", tag, k), 32'(dut_col[k]), 32'(m_col[k]));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s k%0d rvalid%0d", tag, k, p), 32'(dut_rv[k][p]), 32'(m_out_v[k][p]));
                chk($sformatf("%s k%0d rdata%0d", tag, k, p), dut_rd[k][p], m_out_d[k][p]);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("reset");
        #1;
        rst = 1'b0;
    endtask

    task automatic idle();
        oe0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = 4'h0;
        oe1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < D; i++) begin
            mm[0][i] = junk(0, i);
            mm[1][i] = junk(1, i);
            dut_a.mem_q[i] = junk(0, i);
            dut_b.mem_q[i] = junk(1, i);
        end
        tbl[0] = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0,
                   32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, 4'd0, 32'h0, 4'h0,
                   32'hAA22CC44, 32'h0, 32'hAABBCCDD, 32'h0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h0, 4'h0,
                   32'h0, 32'hAA22CC44, 32'h0, 32'hAA22CC44, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'd5, 32'h000000FF, 4'h1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h3,
                   32'h000000FF, 32'h0000FFFF, 32'h0, 32'h0, 1'b0, COL_EN};
        tbl[4] = '{1'b1, 4'd5, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0,
                   32'h0000FFFF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd7, 32'h0, 4'h0,
                   32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 32'h0, 4'h0,
                   32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0};

        @(negedge clk);
        do_reset();

        // Sweep interrupted by reset at address 9 with oe0 held high, then full sweep.
        oe0 = 1'b1;
        repeat (9) step("sweep1");
        do_reset();
        repeat (D) step("sweep2");
        chk("ready after sweep", 32'(dut_ready[0]), 32'd1);

        // Every word of A reads back as zero.
        for (int i = 0; i < D; i++) begin
            oe0 = 1'b1; addr0 = S'(i);
            oe1 = 1'b1; addr1 = S'(D - 1 - i);
            step("readall");
            chk("A zero rdata0", dut_rd[0][0], 32'h0);
            chk("A zero rdata1", dut_rd[0][1], 32'h0);
        end
        idle();
        step("flush");
        step("flush");

        // Table vectors: A checked in the next cycle, B one cycle later still.
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                oe0 = tbl[i].oe0; addr0 = tbl[i].a0; wdata0 = tbl[i].wd0; be0 = tbl[i].be0;
                oe1 = tbl[i].oe1; addr1 = tbl[i].a1; wdata1 = tbl[i].wd1; be1 = tbl[i].be1;
            end else begin
                idle();
            end
            step("tbl");
            if (i < 7) begin
                chk($sformatf("tbl%0d A rvalid0", i), 32'(dut_rv[0][0]), 32'(tbl[i].oe0));
                chk($sformatf("tbl%0d A rvalid1", i), 32'(dut_rv[0][1]), 32'(tbl[i].oe1));
                if (tbl[i].oe0) chk($sformatf("tbl%0d A rdata0", i), dut_rd[0][0], tbl[i].ea0);
                if (tbl[i].oe1) chk($sformatf("tbl%0d A rdata1", i), dut_rd[0][1], tbl[i].ea1);
                chk($sformatf("tbl%0d collision A", i), 32'(dut_col[0]), 32'(tbl[i].col));
                chk($sformatf("tbl%0d collision B", i), 32'(dut_col[1]), 32'(tbl[i].col));
            end
            if (i > 0 && tbl[i-1].cb) begin
                if (tbl[i-1].oe0) chk($sformatf("tbl%0d B rdata0", i - 1), dut_rd[1][0], tbl[i-1].eb0);
                if (tbl[i-1].oe1) chk($sformatf("tbl%0d B rdata1", i - 1), dut_rd[1][1], tbl[i-1].eb1);
            end
        end
        step("flush");
        chk("B word5 high bytes kept", {16'h0, mm[1][5][31:16]}, {16'h0, junk(1, 5) >> 16});

        // Latency-2 burst on B: 8 back-to-back reads.
        for (int j = 0; j < 11; j++) begin
            if (j < 8) begin
                oe0 = 1'b1; addr0 = S'(j); be0 = 4'h0;
            end else begin
                idle();
            end
            step("burst");
            chk($sformatf("burst rvalid0 @%0d", j), 32'(dut_rv[1][0]), 32'((j >= 1) && (j <= 8)));
            if (j >= 1 && j <= 8) chk($sformatf("burst rdata0 @%0d", j), dut_rd[1][0], mm[1][j-1]);
        end

        // Random traffic, narrow address space to provoke same-address interactions.
        for (int n = 0; n < 400; n++) begin
            oe0    = ($urandom_range(0, 3) != 0);
            oe1    = ($urandom_range(0, 3) != 0);
            addr0  = S'($urandom_range(0, (n < 200) ? 3 : 15));
            addr1  = S'($urandom_range(0, (n < 200) ? 3 : 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            be0    = 4'($urandom_range(0, 15));
            be1    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) be0 = 4'h0;
            if ($urandom_range(0, 2) == 0) be1 = 4'h0;
            step("rand");
        end
        idle();
        step("end");
        step("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
